// File: rtl/fifo.sv
// rtl/fifo.sv - single-clock FIFO with chip select, registered read data and full/empty status
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cs,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  full
`ifdef FIFO_ERR_FLAGS_EN
   ,
   output logic                  overflow,
   output logic                  underflow
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [DATA_WIDTH-1:0] mem [0:FIFO_DEPTH-1];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   // MSB is the wrap flag: equal low bits with differing wrap flags means full
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign wr_acc = cs & wr_en & ~full;
   assign rd_acc = cs & rd_en & ~empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         dout   <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (rd_acc) begin
            dout   <= mem[rd_ptr[AW-1:0]];
            rd_ptr <= rd_ptr + PTR_ONE;
         end
      end
   end

   // Storage has no reset so it can map onto plain RAM
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

`ifdef FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (cs && wr_en && full) begin
            overflow <= 1'b1;
         end
         if (cs && rd_en && empty) begin
            underflow <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - directed self-checking bench for fifo
module tb_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] din;
   logic [31:0] dout;
   logic        empty;
   logic        full;
`ifdef FIFO_ERR_FLAGS_EN
   logic        overflow;
   logic        underflow;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   fifo #(.FIFO_DEPTH(8), .DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .cs    (cs),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .din   (din),
      .dout  (dout),
      .empty (empty),
      .full  (full)
`ifdef FIFO_ERR_FLAGS_EN
      ,
      .overflow  (overflow),
      .underflow (underflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic c, input logic w, input logic r, input logic [31:0] d);
      cs    = c;
      wr_en = w;
      rd_en = r;
      din   = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
      n_cmp++; if (dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %0h expected 0", dout); end
   endtask

   task automatic test_basic();
      logic [31:0] vals [3];
      vals[0] = 32'd1; vals[1] = 32'd10; vals[2] = 32'd100;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b1, 1'b0, vals[i]);
         n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL basic_full[%0d]: got %b expected 0", i, full); end
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 32'h0);
         n_cmp++; if (dout !== vals[i]) begin n_fail++; $display("FAIL basic_dout[%0d]: got %0d expected %0d", i, dout, vals[i]); end
      end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty: got %b expected 1", empty); end
   endtask

   task automatic test_interleaved();
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'd1 << i);
         n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL inter_notempty[%0d]: got %b expected 0", i, empty); end
         cyc(1'b1, 1'b0, 1'b1, 32'h0);
         n_cmp++; if (dout !== (32'd1 << i)) begin n_fail++; $display("FAIL inter_dout[%0d]: got %0d expected %0d", i, dout, 32'd1 << i); end
         n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL inter_empty[%0d]: got %b expected 1", i, empty); end
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b1, 1'b0, 32'd1 << i);
         n_cmp++; if (full !== (i == 7)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 7)); end
      end
      cyc(1'b1, 1'b1, 1'b0, 32'hDEAD);
      n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_overwrite_full: got %b expected 1", full); end
      for (int i = 0; i < 8; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 32'h0);
         n_cmp++; if (dout !== (32'd1 << i)) begin n_fail++; $display("FAIL fill_dout[%0d]: got %0h expected %0h", i, dout, 32'd1 << i); end
      end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_empty: got %b expected 1", empty); end
      cyc(1'b1, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (dout !== 32'd128) begin n_fail++; $display("FAIL fill_underflow_dout: got %0d expected 128", dout); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_underflow_empty: got %b expected 1", empty); end
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'd11 + 32'(i));
      cyc(1'b1, 1'b1, 1'b1, 32'd15);
      n_cmp++; if (dout !== 32'd11) begin n_fail++; $display("FAIL simul_dout: got %0d expected 11", dout); end
      n_cmp++; if (empty !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL simul_flags: got empty=%b full=%b expected empty=0 full=0", empty, full); end
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 32'd16 + 32'(i));
      n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL simul_prefull: got %b expected 1", full); end
      cyc(1'b1, 1'b1, 1'b1, 32'd99);
      n_cmp++; if (dout !== 32'd12) begin n_fail++; $display("FAIL simul_full_dout: got %0d expected 12", dout); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL simul_full_drop: got %b expected 0", full); end
      for (int i = 0; i < 7; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 32'h0);
         n_cmp++; if (dout !== 32'd13 + 32'(i)) begin n_fail++; $display("FAIL simul_drain[%0d]: got %0d expected %0d", i, dout, 32'd13 + 32'(i)); end
      end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL simul_drain_empty: got %b expected 1", empty); end
      cyc(1'b1, 1'b1, 1'b1, 32'd55);
      n_cmp++; if (dout !== 32'd19) begin n_fail++; $display("FAIL simul_empty_dout: got %0d expected 19", dout); end
      n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL simul_empty_flag: got %b expected 0", empty); end
      cyc(1'b1, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (dout !== 32'd55) begin n_fail++; $display("FAIL simul_empty_read: got %0d expected 55", dout); end
   endtask

   task automatic test_cs();
      cyc(1'b1, 1'b1, 1'b0, 32'd42);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b1, 1'b1, 32'd7);
         n_cmp++; if (dout !== 32'd55 || empty !== 1'b0 || full !== 1'b0) begin
            n_fail++; $display("FAIL cs_hold[%0d]: got dout=%0d empty=%b full=%b expected dout=55 empty=0 full=0", i, dout, empty, full);
         end
      end
      cyc(1'b1, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (dout !== 32'd42) begin n_fail++; $display("FAIL cs_read: got %0d expected 42", dout); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL cs_empty: got %b expected 1", empty); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 32'd1 + 32'(i));
      cyc(1'b1, 1'b0, 1'b1, 32'h0);
      cyc(1'b1, 1'b1, 1'b0, 32'd6);
      n_cmp++; if (dout !== 32'd1) begin n_fail++; $display("FAIL mid_pre_dout: got %0d expected 1", dout); end
      rst = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, 32'd8);
      rst = 1'b0;
      n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || dout !== 32'h0) begin
         n_fail++; $display("FAIL mid_reset: got empty=%b full=%b dout=%0h expected empty=1 full=0 dout=0", empty, full, dout);
      end
      cyc(1'b1, 1'b1, 1'b0, 32'd77);
      cyc(1'b1, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (dout !== 32'd77) begin n_fail++; $display("FAIL mid_post_read: got %0d expected 77", dout); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL mid_post_empty: got %b expected 1", empty); end
   endtask

`ifdef FIFO_ERR_FLAGS_EN
   task automatic test_err_flags();
      do_reset();
      n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL err_reset: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
      cyc(1'b1, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (underflow !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL err_underflow: got ovf=%b unf=%b expected 0 1", overflow, underflow); end
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 32'(i));
      n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL err_no_ovf_at_full: got %b expected 0", overflow); end
      cyc(1'b1, 1'b1, 1'b0, 32'hBAD);
      n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL err_overflow: got %b expected 1", overflow); end
      cyc(1'b1, 1'b0, 1'b1, 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (overflow !== 1'b1 || underflow !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got ovf=%b unf=%b expected 1 1", overflow, underflow); end
      do_reset();
      n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got ovf=%b unf=%b expected 0 0", overflow, underflow); end
   endtask
`endif

   initial begin
      rst   = 1'b0;
      cs    = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = 32'h0;
      test_reset();
      test_basic();
      test_interleaved();
      test_fill();
      test_simultaneous();
      test_cs();
      test_reset_mid();
`ifdef FIFO_ERR_FLAGS_EN
      test_err_flags();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
